forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, the number of operand read ports per instruction.
REQ-002 SHALL have parameter DEPTH, default 3, the number of tracked producer stages after ID (index 0 = EX, 1 = MEM, 2 = WB); legal range is 3..8.
REQ-003 SHALL have parameter AW, default 5, the register address width; SW = clog2(DEPTH) is derived, not settable.
REQ-004 SHALL have one clock; reset is asynchronous and active-low: ports clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous active-low reset).
REQ-005 id_valid  input  1  an instruction is present in ID.
REQ-006 id_rs  input  NUM_RD*AW  packed read addresses; port p occupies bits [p*AW +: AW].
REQ-007 id_rd_en  input  NUM_RD  port p actually reads its register.
REQ-008 id_early  input  NUM_RD  port p needs its value in ID (jr/branch), not in EX.
REQ-009 id_wr_en, id_wr_addr, id_wr_load  input  1/AW/1  the ID instruction writes id_wr_addr; a load result is late.
REQ-010 flush  input  1  kill the instructions in ID and EX.
REQ-011 stall  output  1  hold IF/ID and insert a bubble into EX.
REQ-012 id_fwd_sel  output  NUM_RD*SW  combinational early-use source: 0 = register file, k = entry k.
REQ-013 ex_fwd_sel  output  NUM_RD*SW  registered EX-use source, aligned with the instruction now in EX: 0 = register file, k = entry k.
REQ-014 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-015 SHALL keep a tag pipeline of DEPTH entries, each holding {valid, addr, load}; it advances every clock.
REQ-016 Entry 0 SHALL load {id_valid & id_wr_en & ~stall & ~flush, id_wr_addr, id_wr_load}; entry i SHALL load entry i-1; entry DEPTH-1 retires (the register file is write-before-read).
REQ-017 Producer latency SHALL be lat = 1 for a non-load and lat = 2 for a load.
REQ-018 For each port p with id_valid & id_rd_en[p] & rs != 0, the match SHALL be the lowest-index valid entry i with addr == rs; older matches are ignored.
REQ-019 EX-use ports (id_early = 0): if i+1 >= lat, the selected source SHALL be i+1, or 0 when i = DEPTH-1; otherwise the port SHALL raise stall.
REQ-020 Early-use ports: if i >= lat, id_fwd_sel SHALL be i; otherwise the port SHALL raise stall; with no match, id_fwd_sel SHALL be 0.
REQ-021 Register 0 SHALL never match, and entries with addr 0 SHALL never be forwarded.
REQ-022 stall SHALL be the OR over all ports, gated by id_valid and ~flush, and SHALL be combinational.
REQ-023 On a clock edge with id_valid & ~stall & ~flush, ex_fwd_sel SHALL load the EX-use selects computed in REQ-019; on stall or flush it SHALL load 0.
REQ-024 The stall state machine SHALL have states RUN and HOLD: RUN->HOLD when stall=1; HOLD->RUN when stall=0; HOLD->RUN on flush.
REQ-025 A load-use stall SHALL last exactly 1 cycle; an early-use stall SHALL last lat-i cycles.
REQ-026 flush SHALL have priority over stall: entry 0 is cleared, ex_fwd_sel is cleared, and older entries still shift.
REQ-027 stall_cnt SHALL increment on every cycle with stall=1 and SHALL saturate at 16'hFFFF.
REQ-028 Simultaneous case: when the same register is both read and written by the ID instruction, the read SHALL see the older producer only.

Reset
REQ-029 On reset=0, all entries SHALL clear valid, and ex_fwd_sel = 0, stall_cnt = 0, FSM = RUN, immediately and without waiting for clk.
REQ-030 While in reset, stall SHALL be 0 and id_fwd_sel SHALL be 0.
REQ-031 Release of reset mid-sequence SHALL start from an empty scoreboard; no stale forwards are permitted.

Verification
REQ-032 ALU $8 in ID, next cycle a consumer reads $8 on port 0 -> stall=0, and the following cycle ex_fwd_sel[0]=1.
REQ-033 Load $9, then a consumer reads $9 on port 1 -> stall=1 for 1 cycle, stall_cnt=1, then ex_fwd_sel[1]=2.
REQ-034 Back-to-back writes to $10 (load, then ALU), then a read of $10 -> the youngest (ALU) is selected, with no stall and ex_fwd_sel=1.
REQ-035 ALU $31, then jr $31 with id_early=1 -> stall=1 for 1 cycle, then id_fwd_sel=1; with a load producer, stall lasts 2 cycles.
REQ-036 A write to $0 followed by a read of $0 -> sel=0, stall=0.
REQ-037 Reset asserted during HOLD -> stall=0 and all outputs 0 asynchronously; flush during a load-use stall -> stall=0 that cycle and ex_fwd_sel=0.

Source files
------------

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight register writers behind ID and picks bypass
// sources for early (ID-stage) and normal (EX-stage) operand use, stalling when data is late.

module forward_scoreboard #(
    parameter  int NUM_RD = 2,
    parameter  int DEPTH  = 3,
    parameter  int AW     = 5,
    localparam int SW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NUM_RD*AW-1:0] id_rs,
    input  logic [NUM_RD-1:0]    id_rd_en,
    input  logic [NUM_RD-1:0]    id_early,
    input  logic                 id_wr_en,
    input  logic [AW-1:0]        id_wr_addr,
    input  logic                 id_wr_load,
    input  logic                 flush,
    output logic                 stall,
    output logic [NUM_RD*SW-1:0] id_fwd_sel,
    output logic [NUM_RD*SW-1:0] ex_fwd_sel,
    output logic [15:0]          stall_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic                 vld_q  [DEPTH];
    logic                 vld_d  [DEPTH];
    logic [AW-1:0]        addr_q [DEPTH];
    logic [AW-1:0]        addr_d [DEPTH];
    logic                 load_q [DEPTH];
    logic                 load_d [DEPTH];
    logic [0:0]           state_q, state_d;
    logic [NUM_RD*SW-1:0] ex_fwd_sel_q, ex_fwd_sel_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;

    logic [NUM_RD-1:0]    port_stall;
    logic [NUM_RD*SW-1:0] id_sel;
    logic [NUM_RD*SW-1:0] ex_sel;
    logic [AW-1:0]        rs;
    logic                 hit;
    logic                 hit_load;
    int                   hit_idx;
    int                   lat;
    logic [15:0]          cnt_inc;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        port_stall = '0;
        id_sel     = '0;
        ex_sel     = '0;
        rs         = '0;
        hit        = 1'b0;
        hit_load   = 1'b0;
        hit_idx    = 0;
        lat        = 1;
        for (int p = 0; p < NUM_RD; p++) begin
            rs       = id_rs[p*AW +: AW];
            hit      = 1'b0;
            hit_load = 1'b0;
            hit_idx  = 0;
            // Scan oldest to youngest so the youngest matching producer wins.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (vld_q[i] && addr_q[i] == rs) begin
                    hit      = 1'b1;
                    hit_idx  = i;
                    hit_load = load_q[i];
                end
            end
            lat = hit_load ? 2 : 1;
            if (id_valid && id_rd_en[p] && rs != '0 && hit) begin
                if (id_early[p]) begin
                    if (hit_idx >= lat) id_sel[p*SW +: SW] = SW'(hit_idx);
                    else                port_stall[p]      = 1'b1;
                end else if (hit_idx + 1 >= lat) begin
                    // The last stage has already written the register file by EX time.
                    ex_sel[p*SW +: SW] = (hit_idx == DEPTH - 1) ? '0 : SW'(hit_idx + 1);
                end else begin
                    port_stall[p] = 1'b1;
                end
            end
        end
    end

    assign stall      = reset & id_valid & ~flush & (|port_stall);
    assign id_fwd_sel = reset ? id_sel : '0;
    assign ex_fwd_sel = ex_fwd_sel_q;
    assign stall_cnt  = stall_cnt_q;
    assign cnt_inc    = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;

    always_comb begin
        vld_d[0]  = id_valid & id_wr_en & ~stall & ~flush;
        addr_d[0] = id_wr_addr;
        load_d[0] = id_wr_load;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
            load_d[i] = load_q[i-1];
        end
        ex_fwd_sel_d = (id_valid & ~stall & ~flush) ? ex_sel : '0;
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d     = ST_HOLD;
                    stall_cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (flush || !stall) state_d     = ST_RUN;
                else                 stall_cnt_d = cnt_inc;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
            ex_fwd_sel_q <= '0;
            stall_cnt_q  <= '0;
            state_q      <= ST_RUN;
        end else begin
            for (int i = 0; i < DEPTH; i++) vld_q[i] <= vld_d[i];
            ex_fwd_sel_q <= ex_fwd_sel_d;
            stall_cnt_q  <= stall_cnt_d;
            state_q      <= state_d;
        end
    end

    // NOTE: only the valid bits need reset; addr/load are never consulted while invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            load_q[i] <= load_d[i];
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a list-of-producers reference model.

module tb_forward_scoreboard;

    localparam int NUM_RD = 2;
    localparam int DEPTH  = 3;
    localparam int AW     = 5;
    localparam int SW     = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 id_valid;
    logic [NUM_RD*AW-1:0] id_rs;
    logic [NUM_RD-1:0]    id_rd_en;
    logic [NUM_RD-1:0]    id_early;
    logic                 id_wr_en;
    logic [AW-1:0]        id_wr_addr;
    logic                 id_wr_load;
    logic                 flush;
    logic                 stall;
    logic [NUM_RD*SW-1:0] id_fwd_sel;
    logic [NUM_RD*SW-1:0] ex_fwd_sel;
    logic [15:0]          stall_cnt;

    always #5 clk = ~clk;

    forward_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rd_en   (id_rd_en),
        .id_early   (id_early),
        .id_wr_en   (id_wr_en),
        .id_wr_addr (id_wr_addr),
        .id_wr_load (id_wr_load),
        .flush      (flush),
        .stall      (stall),
        .id_fwd_sel (id_fwd_sel),
        .ex_fwd_sel (ex_fwd_sel),
        .stall_cnt  (stall_cnt)
    );

    // Reference model: each in-flight writer with its age in cycles since entering EX.
    typedef struct {
        logic [AW-1:0] addr;
        bit            load;
        int            age;
    } prod_t;

    prod_t                inflight[$];
    logic [NUM_RD*SW-1:0] m_ex_sel;
    logic [NUM_RD*SW-1:0] m_ex_next;
    logic [NUM_RD*SW-1:0] m_id_sel;
    bit                   m_stall;
    int                   m_cnt;
    int                   checks   = 0;
    int                   failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_eval();
        bit                   any;
        logic [NUM_RD*SW-1:0] exsel;
        any      = 1'b0;
        exsel    = '0;
        m_id_sel = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic [AW-1:0] r;
            int            best_age;
            bit            best_load;
            int            need;
            r         = id_rs[p*AW +: AW];
            best_age  = -1;
            best_load = 1'b0;
            foreach (inflight[k]) begin
                if (inflight[k].addr == r && (best_age < 0 || inflight[k].age < best_age)) begin
                    best_age  = inflight[k].age;
                    best_load = inflight[k].load;
                end
            end
            if (id_valid && id_rd_en[p] && r != 0 && best_age >= 0) begin
                need = best_load ? 2 : 1;
                if (id_early[p]) begin
                    if (best_age >= need) m_id_sel[p*SW +: SW] = SW'(best_age);
                    else                  any = 1'b1;
                end else begin
                    if (best_age + 1 >= need)
                        exsel[p*SW +: SW] = (best_age == DEPTH - 1) ? SW'(0) : SW'(best_age + 1);
                    else
                        any = 1'b1;
                end
            end
        end
        m_stall = reset && id_valid && !flush && any;
        if (!reset) m_id_sel = '0;
        m_ex_next = (id_valid && !m_stall && !flush) ? exsel : '0;
    endtask

    task automatic model_clock();
        prod_t np;
        foreach (inflight[k]) inflight[k].age++;
        while (inflight.size() > 0 && inflight[0].age >= DEPTH) void'(inflight.pop_front());
        if (id_valid && id_wr_en && !m_stall && !flush) begin
            np.addr = id_wr_addr;
            np.load = id_wr_load;
            np.age  = 0;
            inflight.push_back(np);
        end
        m_ex_sel = m_ex_next;
        if (m_stall && m_cnt < 65535) m_cnt++;
    endtask

    task automatic model_reset();
        inflight.delete();
        m_ex_sel = '0;
        m_cnt    = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        check("stall", stall, m_stall);
        check("id_fwd_sel", id_fwd_sel, m_id_sel);
        check("ex_fwd_sel", ex_fwd_sel, m_ex_sel);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                         input logic [1:0] rden, input logic [1:0] early, input bit wen,
                         input logic [AW-1:0] waddr, input bit wload, input bit fl);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rd_en   = rden;
        id_early   = early;
        id_wr_en   = wen;
        id_wr_addr = waddr;
        id_wr_load = wload;
        flush      = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic drain();
        idle();
        repeat (3) begin
            sample();
            advance();
        end
    endtask

    // Asserts reset between clock edges, checks outputs at once, releases after the next edge.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_id_fwd", id_fwd_sel, 0);
        check("rst_ex_fwd", ex_fwd_sel, 0);
        check("rst_cnt", stall_cnt, 0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    function automatic logic [AW-1:0] raddr();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? AW'(31) : AW'(r);
    endfunction

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", stall, 0);
        check("reset_ex_fwd", ex_fwd_sel, 0);
        check("reset_cnt", stall_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // ALU $8 then consumer on port 0: no stall, MEM bypass next cycle.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 8, 0, 0); sample(); check("r32_prod_stall", stall, 0); advance();
        drive(1, 8, 0, 2'b01, 2'b00, 0, 0, 0, 0); sample(); check("r32_stall", stall, 0); advance();
        idle(); sample(); check("r32_ex_sel0", ex_fwd_sel[1:0], 1); advance();
        drain();

        // Load $9 then consumer on port 1: one stall cycle, then WB bypass.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 9, 1, 0); sample(); advance();
        drive(1, 0, 9, 2'b10, 2'b00, 0, 0, 0, 0); sample();
        check("r33_stall_on", stall, 1); check("r33_cnt0", stall_cnt, 0); advance();
        sample(); check("r33_stall_off", stall, 0); check("r33_cnt1", stall_cnt, 1); advance();
        idle(); sample(); check("r33_ex_sel1", ex_fwd_sel[3:2], 2); advance();
        drain();

        // Load $10 then ALU $10, then a read: youngest producer wins.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 10, 1, 0); sample(); advance();
        drive(1, 0, 0, 2'b00, 2'b00, 1, 10, 0, 0); sample(); advance();
        drive(1, 10, 0, 2'b01, 2'b00, 0, 0, 0, 0); sample(); check("r34_stall", stall, 0); advance();
        idle(); sample(); check("r34_ex_sel0", ex_fwd_sel[1:0], 1); advance();
        drain();

        // ALU $31 then early jr $31: one stall cycle then id_fwd_sel=1.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 31, 0, 0); sample(); advance();
        drive(1, 31, 0, 2'b01, 2'b01, 0, 0, 0, 0); sample();
        check("r35a_stall_on", stall, 1); check("r35a_idsel_hold", id_fwd_sel[1:0], 0); advance();
        sample(); check("r35a_stall_off", stall, 0); check("r35a_idsel", id_fwd_sel[1:0], 1); advance();
        drain();

        // Load $31 then early jr $31: two stall cycles then id_fwd_sel=2.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 31, 1, 0); sample(); advance();
        drive(1, 31, 0, 2'b01, 2'b01, 0, 0, 0, 0); sample(); check("r35b_stall1", stall, 1); advance();
        sample(); check("r35b_stall2", stall, 1); advance();
        sample(); check("r35b_stall_off", stall, 0); check("r35b_idsel", id_fwd_sel[1:0], 2);
        check("r35b_cnt", stall_cnt, 4); advance();
        drain();

        // Write $0 then read $0 on both port kinds: never forwarded.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0); sample(); advance();
        drive(1, 0, 0, 2'b11, 2'b10, 0, 0, 0, 0); sample();
        check("r36_stall", stall, 0); check("r36_idsel", id_fwd_sel, 0); advance();
        idle(); sample(); check("r36_exsel", ex_fwd_sel, 0); advance();
        drain();

        // Reset during an early-use HOLD, then restart from an empty scoreboard.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 5, 1, 0); sample(); advance();
        drive(1, 5, 0, 2'b01, 2'b01, 0, 0, 0, 0); sample(); check("r37_stall1", stall, 1); advance();
        sample(); check("r37_hold_stall", stall, 1);
        async_reset();
        sample(); check("r31_no_stale_stall", stall, 0); check("r31_no_stale_sel", id_fwd_sel, 0); advance();
        drain();

        // Flush during a load-use stall: stall drops, EX select cleared.
        drive(1, 0, 0, 2'b00, 2'b00, 1, 9, 1, 0); sample(); advance();
        drive(1, 9, 0, 2'b01, 2'b00, 0, 0, 0, 1); sample(); check("r37_flush_stall", stall, 0); advance();
        drive(1, 9, 0, 2'b01, 2'b00, 0, 0, 0, 0); sample(); check("r37_flush_exsel", ex_fwd_sel, 0); advance();
        drain();

        // Randomized traffic; a stalled instruction is usually held, as the pipeline would.
        for (int n = 0; n < 3000; n++) begin
            if (!(m_stall && $urandom_range(0, 7) != 0)) begin
                drive($urandom_range(0, 7) != 0, raddr(), raddr(), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, raddr(),
                      $urandom_range(0, 2) == 0, 0);
            end
            flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 599) == 0) begin
                sample();
                async_reset();
            end
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
